// File: rtl/xnor3_bist_ctrl.sv
// BIST sequencer for one XNOR3 cell: walks the 8 Gray-ordered input vectors, samples ZN after a settle delay and scores it.
// Optional first-fail capture (FF_VLD/FF_IDX) is built only when XNOR3_BIST_FFAIL_EN is defined.
module xnor3_bist_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int ITER       = 1,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [7:0]       FAIL_VEC
`ifdef XNOR3_BIST_FFAIL_EN
  ,
  output logic             FF_VLD,
  output logic [2:0]       FF_IDX
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam int               ITER_EFF    = (ITER < 1) ? 1 : ITER;
  localparam logic [31:0]      LAST_SWEEP  = 32'(ITER_EFF - 1);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] ERR_MAX     = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [2:0]       idx;
  logic [31:0]      sweepCnt;
  logic [7:0]       settleCnt;
  logic             expZn;
  logic             mism;
  logic             settleHit;
  logic             lastVec;
  logic [2:0]       nextIdx;
  logic [CNT_W-1:0] errNext;

  function automatic logic [2:0] gray(input logic [2:0] i);
    return i ^ {1'b0, i[2:1]};
  endfunction

  // An X/Z on ZN fails the equality and therefore falls through as a mismatch.
  always_comb begin
    expZn     = ~(A1 ^ A2 ^ A3);
    mism      = 1'b1;
    if (ZN == expZn) mism = 1'b0;
    settleHit = (settleCnt == 8'd1);
    lastVec   = (idx == 3'd7) && (sweepCnt == LAST_SWEEP);
    nextIdx   = idx + 3'd1;
    errNext   = ERR_CNT;
    if (mism && (ERR_CNT != ERR_MAX)) errNext = ERR_CNT + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      idx          <= 3'd0;
      sweepCnt     <= 32'd0;
      settleCnt    <= 8'd0;
      {A3, A2, A1} <= 3'b000;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      PASS         <= 1'b0;
      ERR_CNT      <= '0;
      FAIL_VEC     <= 8'h00;
`ifdef XNOR3_BIST_FFAIL_EN
      FF_VLD       <= 1'b0;
      FF_IDX       <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            BUSY         <= 1'b1;
            PASS         <= 1'b0;
            ERR_CNT      <= '0;
            FAIL_VEC     <= 8'h00;
            idx          <= 3'd0;
            sweepCnt     <= 32'd0;
            {A3, A2, A1} <= gray(3'd0);
            settleCnt    <= SETTLE_LOAD;
            state        <= SETTLE;
`ifdef XNOR3_BIST_FFAIL_EN
            FF_VLD       <= 1'b0;
            FF_IDX       <= 3'd0;
`endif
          end
        end
        SETTLE: begin
          if (ABORT) begin
            BUSY         <= 1'b0;
            PASS         <= 1'b0;
            {A3, A2, A1} <= 3'b000;
            state        <= IDLE;
          end else if (settleHit) begin
            ERR_CNT <= errNext;
            if (mism) begin
              FAIL_VEC[idx] <= 1'b1;
`ifdef XNOR3_BIST_FFAIL_EN
              if (!FF_VLD) begin
                FF_VLD <= 1'b1;
                FF_IDX <= idx;
              end
`endif
            end
            if (lastVec) begin
              DONE         <= 1'b1;
              BUSY         <= 1'b0;
              PASS         <= (errNext == '0);
              {A3, A2, A1} <= 3'b000;
              state        <= FINISH;
            end else begin
              idx          <= nextIdx;
              {A3, A2, A1} <= gray(nextIdx);
              settleCnt    <= SETTLE_LOAD;
              if (idx == 3'd7) sweepCnt <= sweepCnt + 32'd1;
            end
          end else begin
            settleCnt <= settleCnt - 8'd1;
          end
        end
        FINISH: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor3_bist_ctrl.sv
// Scoreboard bench for xnor3_bist_ctrl: runs push expected results, a negedge monitor pops them on each DONE.
// Honors XNOR3_BIST_FFAIL_EN to also score the first-fail outputs.
module tb_xnor3_bist_ctrl;

  typedef struct {
    int         doneEdge;
    logic [7:0] err;
    logic [7:0] fv;
    logic       pass;
    logic       ffv;
    logic [2:0] ffi;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start1 = 1'b0;
  logic       abort1 = 1'b0;
  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic       zn1;
  logic       zn2;
  logic [1:0] mode = 2'd0;

  logic       a1, a2, a3, busy, done, pass;
  logic [7:0] errCnt, failVec;
  logic       b1, b2, b3, busy2, done2, pass2;
  logic [2:0] errCnt2;
  logic [7:0] failVec2;
`ifdef XNOR3_BIST_FFAIL_EN
  logic       ffVld, ffVld2;
  logic [2:0] ffIdx, ffIdx2;
`endif

  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;
  logic prevDone = 1'b0;
  logic prevDone2 = 1'b0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  // Cell model on ZN: ideal, stuck-at-1, stuck-at-0, or wrong only for vector 101.
  always_comb begin
    zn1 = ~(a1 ^ a2 ^ a3);
    case (mode)
      2'd1: zn1 = 1'b1;
      2'd2: zn1 = 1'b0;
      2'd3: if ({a3, a2, a1} == 3'b101) zn1 = a1 ^ a2 ^ a3;
      default: ;
    endcase
  end
  assign zn2 = 1'b0;

  xnor3_bist_ctrl #(.SETTLE_CYC(2), .ITER(1), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .START(start1), .ABORT(abort1), .ZN(zn1),
    .A1(a1), .A2(a2), .A3(a3), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(errCnt), .FAIL_VEC(failVec)
`ifdef XNOR3_BIST_FFAIL_EN
    , .FF_VLD(ffVld), .FF_IDX(ffIdx)
`endif
  );

  xnor3_bist_ctrl #(.SETTLE_CYC(2), .ITER(3), .CNT_W(3)) dut2 (
    .CLK(CLK), .RST(RST), .START(start2), .ABORT(abort2), .ZN(zn2),
    .A1(b1), .A2(b2), .A3(b3), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_CNT(errCnt2), .FAIL_VEC(failVec2)
`ifdef XNOR3_BIST_FFAIL_EN
    , .FF_VLD(ffVld2), .FF_IDX(ffIdx2)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Pops the oldest expected result for the selected DUT and scores the completed run.
  task automatic scoreDone(input bit second);
    exp_t e;
    if ((second ? q2.size() : q1.size()) == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_done dut%0d actual=1 expected=0", second ? 2 : 1);
    end else begin
      e = second ? q2.pop_front() : q1.pop_front();
      checkOutput("done_edge", 32'(cycle), 32'(e.doneEdge));
      if (second) begin
        checkOutput("err_cnt2", 32'(errCnt2), 32'(e.err));
        checkOutput("fail_vec2", 32'(failVec2), 32'(e.fv));
        checkOutput("pass_busy2", {30'b0, pass2, busy2}, {30'b0, e.pass, 1'b0});
`ifdef XNOR3_BIST_FFAIL_EN
        checkOutput("first_fail2", {28'b0, ffVld2, ffIdx2}, {28'b0, e.ffv, e.ffi});
`endif
      end else begin
        checkOutput("err_cnt", 32'(errCnt), 32'(e.err));
        checkOutput("fail_vec", 32'(failVec), 32'(e.fv));
        checkOutput("pass_busy_a", {27'b0, pass, busy, a3, a2, a1}, {27'b0, e.pass, 4'b0000});
`ifdef XNOR3_BIST_FFAIL_EN
        checkOutput("first_fail", {28'b0, ffVld, ffIdx}, {28'b0, e.ffv, e.ffi});
`endif
      end
    end
  endtask

  // Monitor: decoupled from stimulus, reacts only to DONE.
  always @(negedge CLK) begin
    if (RST) begin
      prevDone  = 1'b0;
      prevDone2 = 1'b0;
    end else begin
      if (done) begin
        checkOutput("done_width", {31'b0, prevDone}, 32'd0);
        scoreDone(1'b0);
      end
      if (done2) begin
        checkOutput("done_width2", {31'b0, prevDone2}, 32'd0);
        scoreDone(1'b1);
      end
      prevDone  = done;
      prevDone2 = done2;
    end
  end

  task automatic applyStimulus(input bit second, input logic [7:0] expErr, input logic [7:0] expFv,
                               input logic expPass, input logic expFfv, input logic [2:0] expFfi);
    exp_t e;
    @(negedge CLK);
    e.doneEdge = cycle + 1 + (second ? 48 : 16);
    e.err  = expErr;
    e.fv   = expFv;
    e.pass = expPass;
    e.ffv  = expFfv;
    e.ffi  = expFfi;
    if (second) begin
      q2.push_back(e);
      start2 = 1'b1;
    end else begin
      q1.push_back(e);
      start1 = 1'b1;
    end
    @(negedge CLK);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic waitRunEnd(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("[TB] FAIL run_timeout actual=%0d pending expected=0", q1.size() + q2.size());
    end
    repeat (3) @(negedge CLK);
  endtask

  function automatic logic [2:0] grayOf(input int i);
    logic [2:0] g;
    case (i)
      0: g = 3'b000;  1: g = 3'b001;  2: g = 3'b011;  3: g = 3'b010;
      4: g = 3'b110;  5: g = 3'b111;  6: g = 3'b101;  default: g = 3'b100;
    endcase
    return g;
  endfunction

  initial begin
    repeat (3) @(negedge CLK);
    checkOutput("reset_outs", {10'b0, a3, a2, a1, busy, done, pass, errCnt, failVec}, 32'd0);
    checkOutput("reset_outs2", {13'b0, b3, b2, b1, busy2, done2, pass2, errCnt2, failVec2}, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    $display("[TB] test 1: ideal cell, Gray walk");
    mode = 2'd0;
    applyStimulus(1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 3'd0);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) repeat (2) @(negedge CLK);
      checkOutput($sformatf("gray_vec%0d", j), {28'b0, busy, a3, a2, a1}, {28'b0, 1'b1, grayOf(j)});
    end
    waitRunEnd(200);

    $display("[TB] test 2: ZN stuck at 1");
    mode = 2'd1;
    applyStimulus(1'b0, 8'd4, 8'hAA, 1'b0, 1'b1, 3'd1);
    waitRunEnd(200);
    checkOutput("hold_between_runs", {23'b0, pass, errCnt}, {23'b0, 1'b0, 8'd4});

    $display("[TB] test 3: ZN stuck at 0, 3 sweeps, 3-bit counter");
    applyStimulus(1'b1, 8'd7, 8'h55, 1'b0, 1'b1, 3'd0);
    waitRunEnd(300);

    $display("[TB] test 4: abort at index 3");
    applyStimulus(1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 3'd0);
    void'(q1.pop_back());
    repeat (6) @(negedge CLK);
    abort1 = 1'b1;
    @(negedge CLK);
    abort1 = 1'b0;
    checkOutput("abort_outs", {27'b0, busy, pass, a3, a2, a1}, 32'd0);
    checkOutput("abort_partial", {16'b0, errCnt, failVec}, {16'b0, 8'd1, 8'h02});
    repeat (20) @(negedge CLK);
    mode = 2'd0;
    applyStimulus(1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 3'd0);
    waitRunEnd(200);

    $display("[TB] test 5: START while busy, then RST mid-run");
    applyStimulus(1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 3'd0);
    repeat (4) @(negedge CLK);
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    waitRunEnd(200);
    mode = 2'd1;
    @(negedge CLK);
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("rst_midrun", {10'b0, a3, a2, a1, busy, done, pass, errCnt, failVec}, 32'd0);
`ifdef XNOR3_BIST_FFAIL_EN
    checkOutput("rst_midrun_ff", {28'b0, ffVld, ffIdx}, 32'd0);
`endif
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);

    $display("[TB] test 6: ZN wrong only for vector 101");
    mode = 2'd3;
    applyStimulus(1'b0, 8'd1, 8'h40, 1'b0, 1'b1, 3'd6);
    waitRunEnd(200);

    checkOutput("scoreboard_empty", 32'(q1.size() + q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
